// File: rtl/debug_pipe_pkg.sv
// debug_pipe_pkg
// Shared definitions for the debug pipe-out framer and its prefetch queue.
// Contents: the framer state enum, the trailer header byte, the trailer
// field widths and a helper that assembles a trailer word.
package debug_pipe_pkg;

   localparam int WORD_W        = 32;
   localparam int SEQ_FIELD_W   = 8;
   localparam int COUNT_FIELD_W = 16;

   localparam logic [7:0] TRAILER_HDR = 8'hDB;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_READY,
      ST_STREAM
   } pipe_state_t;

   // Trailer layout: header byte, low byte of the block sequence, payload count.
   function automatic logic [WORD_W-1:0] make_trailer(
      input logic [SEQ_FIELD_W-1:0]   seq,
      input logic [COUNT_FIELD_W-1:0] cnt
   );
      return {TRAILER_HDR, seq, cnt};
   endfunction

endpackage

// File: rtl/debug_prefetch_q2.sv
// debug_prefetch_q2
// Two-entry prefetch queue sitting between the upstream FIFO and the framer.
// It issues FIFO reads only while stored words plus outstanding reads stay
// below two, so the queue can never overflow.
// Ports:
//   rd_clk, rstn      clock / async active-low reset
//   fifo_empty        upstream FIFO empty flag
//   fifo_valid        upstream read data valid (one cycle after fifo_rd_en)
//   fifo_dout         upstream read data
//   fifo_rd_en        upstream read request
//   pop               consume the head word this cycle
//   head              current head word
//   q_empty           queue holds no words
module debug_prefetch_q2
   import debug_pipe_pkg::*;
(
   input  logic              rd_clk,
   input  logic              rstn,
   input  logic              fifo_empty,
   input  logic              fifo_valid,
   input  logic [WORD_W-1:0] fifo_dout,
   output logic              fifo_rd_en,
   input  logic              pop,
   output logic [WORD_W-1:0] head,
   output logic              q_empty
);

   logic [WORD_W-1:0] slot0;
   logic [WORD_W-1:0] slot1;
   logic [1:0]        occ;
   logic [1:0]        in_flight;
   logic              push;
   logic              do_pop;

   // Read request and push/pop qualification. A returning word is only
   // accepted when a read is known to be outstanding, which drops data from
   // reads issued before a reset.
   always_comb begin
      fifo_rd_en = rstn && !fifo_empty &&
                   (({1'b0, occ} + {1'b0, in_flight}) < 3'd2);
      do_pop     = pop && (occ != 2'd0);
      push       = fifo_valid && (in_flight != 2'd0) &&
                   ((occ != 2'd2) || do_pop);
      head       = slot0;
      q_empty    = (occ == 2'd0);
   end

   // Outstanding read tracking.
   always_ff @(posedge rd_clk or negedge rstn) begin
      if (!rstn) begin
         in_flight <= 2'd0;
      end else begin
         case ({fifo_rd_en, fifo_valid && (in_flight != 2'd0)})
            2'b10:   in_flight <= in_flight + 2'd1;
            2'b01:   in_flight <= in_flight - 2'd1;
            default: in_flight <= in_flight;
         endcase
      end
   end

   // Storage: slot0 is always the head; a simultaneous push and pop keeps
   // occupancy unchanged.
   always_ff @(posedge rd_clk or negedge rstn) begin
      if (!rstn) begin
         slot0 <= '0;
         slot1 <= '0;
         occ   <= 2'd0;
      end else begin
         case ({push, do_pop})
            2'b10: begin
               if (occ == 2'd0) slot0 <= fifo_dout;
               else             slot1 <= fifo_dout;
               occ <= occ + 2'd1;
            end
            2'b01: begin
               slot0 <= slot1;
               occ   <= occ - 2'd1;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  slot0 <= fifo_dout;
               end else begin
                  slot0 <= slot1;
                  slot1 <= fifo_dout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/debug_pipeout_framer.sv
// debug_pipeout_framer
// Frames upstream FIFO data into fixed-length host pipe-out blocks. Each block
// is BLOCK_WORDS words: payload (padded with FILL_WORD once data runs out)
// followed by a trailer {8'hDB, seq[7:0], payload_count[15:0]}. A block starts
// on fifo_prog_full or after TIMEOUT_CYC cycles of pending data.
// Ports:
//   rd_clk, rstn                  clock / async active-low reset
//   fifo_dout, fifo_valid         upstream read data and its valid
//   fifo_empty, fifo_prog_full    upstream status
//   fifo_rd_en                    upstream read request
//   po_ready                      block available to host
//   po_read                       host word-read strobe
//   po_data                       current word to host
//   blk_seq                       completed-block count
//   err_read                      sticky flag: host read outside a block
module debug_pipeout_framer
   import debug_pipe_pkg::*;
#(
   parameter int unsigned BLOCK_WORDS = 256,
   parameter int unsigned TIMEOUT_CYC = 65535,
   parameter logic [31:0] FILL_WORD   = 32'h0000_0000
)(
   input  logic                     rd_clk,
   input  logic                     rstn,
   input  logic [WORD_W-1:0]        fifo_dout,
   input  logic                     fifo_valid,
   input  logic                     fifo_empty,
   input  logic                     fifo_prog_full,
   output logic                     fifo_rd_en,
   output logic                     po_ready,
   input  logic                     po_read,
   output logic [WORD_W-1:0]        po_data,
   output logic [15:0]              blk_seq,
   output logic                     err_read
);

   localparam int IDX_W = (BLOCK_WORDS > 2) ? $clog2(BLOCK_WORDS) : 1;
   localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_WORDS - 1);
   localparam logic [TMR_W-1:0] TMR_END  = TMR_W'(TIMEOUT_CYC);

   pipe_state_t              state;
   pipe_state_t              state_nxt;
   logic [IDX_W-1:0]         idx;
   logic [IDX_W-1:0]         next_idx;
   logic                     pad;
   logic [COUNT_FIELD_W-1:0] pay_cnt;
   logic [TMR_W-1:0]         timer;
   logic [WORD_W-1:0]        q_head;
   logic                     q_empty;
   logic                     q_pop;
   logic                     host_adv;
   logic                     stray_rd;
   logic                     at_trailer;
   logic                     load_word;
   logic                     load_is_trailer;
   logic                     take_data;

   debug_prefetch_q2 u_prefetch (
      .rd_clk     (rd_clk),
      .rstn       (rstn),
      .fifo_empty (fifo_empty),
      .fifo_valid (fifo_valid),
      .fifo_dout  (fifo_dout),
      .fifo_rd_en (fifo_rd_en),
      .pop        (q_pop),
      .head       (q_head),
      .q_empty    (q_empty)
   );

   // State register.
   always_ff @(posedge rd_clk or negedge rstn) begin
      if (!rstn) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic: the block ends when the host reads the trailer.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:   if (fifo_prog_full || (timer == TMR_END)) state_nxt = ST_LOAD;
         ST_LOAD:   state_nxt = ST_READY;
         ST_READY:  if (po_read) state_nxt = (idx == LAST_IDX) ? ST_IDLE : ST_STREAM;
         ST_STREAM: if (po_read && (idx == LAST_IDX)) state_nxt = ST_IDLE;
         default:   state_nxt = ST_IDLE;
      endcase
   end

   // Output and word-load decisions. A word is loaded on entry (LOAD) and on
   // every host read that is not the trailer read. Once padding starts it
   // stays on until the block ends, even if data reappears.
   always_comb begin
      po_ready        = (state == ST_READY);
      host_adv        = po_read && ((state == ST_READY) || (state == ST_STREAM));
      stray_rd        = po_read && ((state == ST_IDLE) || (state == ST_LOAD));
      at_trailer      = (idx == LAST_IDX);
      next_idx        = idx + 1'b1;
      load_word       = (state == ST_LOAD) || (host_adv && !at_trailer);
      load_is_trailer = (state != ST_LOAD) && (next_idx == LAST_IDX);
      take_data       = load_word && !load_is_trailer && !q_empty &&
                        ((state == ST_LOAD) || !pad);
      q_pop           = take_data;
   end

   // Framing datapath: index, pad flag, payload count, output word,
   // sequence counter, timer and the stray-read flag.
   always_ff @(posedge rd_clk or negedge rstn) begin
      if (!rstn) begin
         idx      <= '0;
         pad      <= 1'b0;
         pay_cnt  <= '0;
         timer    <= '0;
         po_data  <= '0;
         blk_seq  <= '0;
         err_read <= 1'b0;
      end else begin
         if (stray_rd) err_read <= 1'b1;

         if (host_adv && at_trailer) begin
            timer   <= '0;
            blk_seq <= blk_seq + 16'd1;
         end else if (state == ST_IDLE) begin
            if (!q_empty || !fifo_empty)
               timer <= (timer == TMR_END) ? timer : timer + 1'b1;
            else
               timer <= '0;
         end

         if (state == ST_LOAD) begin
            idx     <= '0;
            pad     <= !take_data;
            pay_cnt <= take_data ? 16'd1 : 16'd0;
            po_data <= take_data ? q_head : FILL_WORD;
         end else if (load_word) begin
            idx <= next_idx;
            if (load_is_trailer) begin
               po_data <= make_trailer(blk_seq[SEQ_FIELD_W-1:0], pay_cnt);
            end else if (take_data) begin
               po_data <= q_head;
               pay_cnt <= pay_cnt + 16'd1;
            end else begin
               po_data <= FILL_WORD;
               pad     <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/debug_pipeout_framer.md
DEBUG_PIPEOUT_FRAMER -- requirements
Module: debug_pipeout_framer

Interface
REQ-001 SHALL have parameter BLOCK_WORDS, default 256: pipe-out block length in 32-bit words, trailer included; legal range 2..65536.
REQ-002 SHALL have parameter TIMEOUT_CYC, default 65535: rd_clk cycles of pending data without prog_full before a partial-block flush.
REQ-003 SHALL have parameter FILL_WORD, default 32'h0000_0000: pad word.
REQ-004 SHALL have ports: rd_clk  in  1  clock, all logic on rising edge.
REQ-005 SHALL have ports: rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: fifo_dout  in  32  upstream FIFO read data.
REQ-007 SHALL have ports: fifo_valid  in  1  fifo_dout valid, one cycle after an accepted fifo_rd_en.
REQ-008 SHALL have ports: fifo_empty  in  1, and fifo_prog_full  in  1  upstream FIFO status.
REQ-009 SHALL have ports: fifo_rd_en  out  1  upstream read request.
REQ-010 SHALL have ports: po_ready  out  1  block available to host.
REQ-011 SHALL have ports: po_read  in  1  host word-read strobe.
REQ-012 SHALL have ports: po_data  out  32  current word to host.
REQ-013 SHALL have ports: blk_seq  out  16  completed-block count; err_read  out  1  sticky stray-read flag.

Function
REQ-014 SHALL hold a 2-entry prefetch queue; assert fifo_rd_en only when !fifo_empty and queue occupancy + in-flight reads < 2; push fifo_dout on fifo_valid.
REQ-015 SHALL implement states IDLE, LOAD, READY, STREAM.
REQ-016 IDLE: timer counts while queue non-empty or !fifo_empty, otherwise clears; go to LOAD when fifo_prog_full=1 or timer==TIMEOUT_CYC.
REQ-017 LOAD (one cycle): word index=0, pad flag clear, payload count=0; load word 0 into po_data; go to READY.
REQ-018 READY: po_ready=1, po_data stable; on po_read go to STREAM; po_ready drops the following cycle.
REQ-019 Each po_read in READY/STREAM in cycle t SHALL advance the index; po_data at t+1 holds the next word.
REQ-020 Word load, index 0..BLOCK_WORDS-2: if pad flag clear and queue non-empty, pop head and increment payload count; otherwise FILL_WORD and set pad flag (sticky to block end).
REQ-021 Index BLOCK_WORDS-1 SHALL be the trailer {8'hDB, blk_seq[7:0], payload_count[15:0]}.
REQ-022 po_read on the trailer SHALL increment blk_seq (wraps 16'hFFFF->0), clear timer, and return to IDLE.
REQ-023 Prefetch SHALL continue while pad flag is set; queued words are carried to the next block.
REQ-024 po_read in IDLE or LOAD SHALL set err_read and be otherwise ignored.
REQ-025 A pop and a push in the same cycle SHALL keep occupancy unchanged; the queue SHALL never overflow.

Reset
REQ-026 On rstn=0 (async) SHALL enter IDLE: po_ready=0, po_data=0, fifo_rd_en=0, blk_seq=0, err_read=0, queue empty, timer/index/count=0.
REQ-027 Reset mid-block SHALL abandon the block; in-flight FIFO data returning after release SHALL be discarded.

Structure
REQ-028 State enum, header byte 8'hDB, and trailer field widths SHALL live in shared package debug_pipe_pkg.
REQ-029 Prefetch queue SHALL be sub-module debug_prefetch_q2; FSM, timer, framing stay in top.

Verification
REQ-030 prog_full=1, 300 words queued, BLOCK_WORDS=256, 256 reads -> words 0..254 in order, trailer 32'hDB00_00FF, blk_seq=1.
REQ-031 3 words then idle, TIMEOUT_CYC=100 -> po_ready rises ~102 cycles later; block = 3 data, 252 FILL_WORD, trailer 32'hDB00_0003.
REQ-032 FIFO runs dry at word 10 and refills mid-block -> words 10..254 are FILL_WORD, count=10, refilled data leads next block.
REQ-033 po_read while IDLE -> err_read=1, po_data unchanged, no queue pop.
REQ-034 rstn low mid-STREAM -> all outputs at reset values within the same cycle; clean block after release.
REQ-035 65536 back-to-back blocks (BLOCK_WORDS=2) -> blk_seq wraps to 0, trailer sequence byte wraps 8'hFF->8'h00.
